mips_boot_loader: RTL
=====================

Name: mips_boot_loader

Overview:
- Upstream loader for MIPS_top. Consumes a byte stream (UART/host side) carrying framed load commands.
- Assembles big-endian 32-bit words and drives MIPS_top's I-cache and D-cache write ports (IData_in/IAddr_in/icache_we, DData_in/DAddr_in/dcache_we).
- Raises start once loading is complete, replacing hand-driven bench stimulus in the real top level.

Parameters:
- CNT_W, 16, width of the word-count field; fixed at 2 header bytes, so only the value 16 is legal.
- ADDR_W, 16, width of the load-address field (2 header bytes); addresses are zero-extended to 32 bits on output.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-low (asserted when 0, sampled on rising clk)
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte; transfer occurs when in_valid && in_ready at a rising edge
- IData_in  out  32  I-cache write data
- IAddr_in  out  32  I-cache word address
- icache_we  out  1  I-cache write strobe
- DData_in  out  32  D-cache write data
- DAddr_in  out  32  D-cache word address
- dcache_we  out  1  D-cache write strobe
- start  out  1  processor run enable
- busy  out  1  frame in progress (state not IDLE/RUN)
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst==0 at an edge) values:
  - All outputs 0, except in_ready=1.
  - State=IDLE; partial word, address and count are cleared.
  - A reset mid-frame discards the partial word. Writes already issued stay in the caches.
- Frame format, all fields big-endian: CMD, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT×4 payload bytes.
- Commands:
  - 0x49 'I' = I-cache load.
  - 0x44 'D' = D-cache load.
  - 0x47 'G' = go. A 'G' frame has no further bytes.
- States:
  - IDLE.
  - ADDR_HI, ADDR_LO.
  - CNT_HI, CNT_LO.
  - PAYLOAD.
  - CHECK (feature only).
  - RUN.
  - Each accepted byte advances the state exactly once.
- IDLE transitions:
  - 'I'/'D': latch the target cache, go to ADDR_HI.
  - 'G': go to RUN.
  - Any other byte: set err=1 (sticky until reset) and stay in IDLE.
- CNT_LO transitions:
  - CNT≠0: go to PAYLOAD.
  - CNT=0: go to IDLE (or CHECK when the feature is compiled in). No writes are issued.
- PAYLOAD:
  - A byte counter 0..3 shifts bytes into the word, first byte = bits[31:24].
  - On acceptance of the 4th byte, the next cycle drives Data/Addr with the selected cache's we=1 for exactly one cycle.
  - The other cache's we stays 0.
  - Data/Addr outputs hold their last values while we=0.
- Address handling:
  - The address register increments by 1 after each write and wraps 0xFFFF→0x0000 with no error.
  - The remaining-word count decrements per write. The last write returns the state to IDLE (or CHECK).
- Throughput: back-to-back bytes are accepted every cycle; in_ready stays 1 in every state except RUN.
- RUN:
  - start=1 from the cycle after 'G' is accepted.
  - in_ready=0 and start stays 1 until reset. Later bytes are ignored.
- busy=1 in ADDR_HI through CHECK.
- Latency: last payload byte accepted at edge N → we high during cycle N+1.

Optional Feature:
- Macro: MIPS_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last payload byte (or CNT_LO when CNT=0), a CHECK state accepts one byte.
  - That byte must equal the XOR of all header bytes after CMD plus all payload bytes.
  - Mismatch sets err=1. Writes already performed are not undone.
  - Either way the state then returns to IDLE.
- Without the macro: there is no CHECK state, and a frame ends after its payload.

Decomposition:
- Package mips_loader_pkg holds:
  - state encoding constants;
  - command byte constants CMD_ILOAD=8'h49, CMD_DLOAD=8'h44, CMD_GO=8'h47.
- Sub-module loader_word_asm: byte shift register, 0..3 byte counter and word_done pulse, with clear on rst or frame start.
- The top-level FSM handles counts, addresses, strobe routing and checksum.

Test Plan:
- D frame 44 0000 0005 + words 42,23,16,8,156 → five dcache_we pulses, DAddr_in 0..4, DData_in 42,23,16,8,156; icache_we never 1.
- I frame at addr 0, CNT=2, words 20080005, 20090001 → icache_we ×2, IAddr_in 0,1, matching IData_in; then byte 47 → start=1 next cycle, in_ready=0.
- Byte 0x55 in IDLE → err=1 and held; a following valid D frame still writes correctly.
- D frame at addr FFFF, CNT=2 → writes at DAddr_in 0000FFFF then 00000000.
- rst=0 after 2 payload bytes → all outputs 0, in_ready=1; a fresh frame writes correct words with no stale bytes.
- With MIPS_LOADER_CHECKSUM_EN: correct XOR byte → err stays 0; wrong byte → err=1, state returns to IDLE; CNT=0 frame checks a header-only XOR.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared encodings for the MIPS boot loader: state codes, command bytes, field widths.
package mips_loader_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 32;

  localparam logic [7:0] CMD_ILOAD = 8'h49;
  localparam logic [7:0] CMD_DLOAD = 8'h44;
  localparam logic [7:0] CMD_GO    = 8'h47;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_CNT_HI  = 3'd3,
    S_CNT_LO  = 3'd4,
    S_PAYLOAD = 3'd5,
    S_CHECK   = 3'd6,
    S_RUN     = 3'd7
  } state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian word assembler: shifts payload bytes in and flags the 4th byte of each word.
module loader_word_asm
  import mips_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_done_c
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (byte_en) begin
      sr  <= {sr[15:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end

  // The completed word includes the byte being accepted this cycle.
  assign word_c      = {sr, byte_in};
  assign word_done_c = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/mips_boot_loader.sv
// Framed byte-stream loader feeding MIPS_top I/D caches and raising start on 'G'.
// Optional trailing XOR check byte per frame when MIPS_LOADER_CHECKSUM_EN is defined.
module mips_boot_loader
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] IData_in,
  output logic [31:0] IAddr_in,
  output logic        icache_we,
  output logic [31:0] DData_in,
  output logic [31:0] DAddr_in,
  output logic        dcache_we,
  output logic        start,
  output logic        busy,
  output logic        err
);

`ifdef MIPS_LOADER_CHECKSUM_EN
  localparam state_t FRAME_END = S_CHECK;
  logic [7:0] csum, csum_n;
`else
  localparam state_t FRAME_END = S_IDLE;
`endif

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              tgt_d, tgt_d_n;
  logic              in_ready_n, icache_we_n, dcache_we_n, start_n, busy_n, err_n;
  logic [31:0]       idata_n, iaddr_n, ddata_n, daddr_n;
  logic              accept_c, frame_start_c, pay_en_c, word_done_c;
  logic [WORD_W-1:0] word_c;

  assign accept_c      = in_valid && in_ready;
  assign frame_start_c = accept_c && (state == S_IDLE);
  assign pay_en_c      = accept_c && (state == S_PAYLOAD);

  loader_word_asm u_word_asm (
    .clk         (clk),
    .rst         (rst),
    .clr         (frame_start_c),
    .byte_en     (pay_en_c),
    .byte_in     (in_data),
    .word_c      (word_c),
    .word_done_c (word_done_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      cnt       <= '0;
      tgt_d     <= 1'b0;
      in_ready  <= 1'b1;
      IData_in  <= '0;
      IAddr_in  <= '0;
      icache_we <= 1'b0;
      DData_in  <= '0;
      DAddr_in  <= '0;
      dcache_we <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      cnt       <= cnt_n;
      tgt_d     <= tgt_d_n;
      in_ready  <= in_ready_n;
      IData_in  <= idata_n;
      IAddr_in  <= iaddr_n;
      icache_we <= icache_we_n;
      DData_in  <= ddata_n;
      DAddr_in  <= daddr_n;
      dcache_we <= dcache_we_n;
      start     <= start_n;
      busy      <= busy_n;
      err       <= err_n;
`ifdef MIPS_LOADER_CHECKSUM_EN
      csum      <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    cnt_n       = cnt;
    tgt_d_n     = tgt_d;
    err_n       = err;
    start_n     = start;
    idata_n     = IData_in;
    iaddr_n     = IAddr_in;
    icache_we_n = 1'b0;
    ddata_n     = DData_in;
    daddr_n     = DAddr_in;
    dcache_we_n = 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
    csum_n      = csum;
`endif
    if (accept_c) begin
      case (state)
        S_IDLE: begin
          case (in_data)
            CMD_ILOAD: begin tgt_d_n = 1'b0; state_n = S_ADDR_HI; end
            CMD_DLOAD: begin tgt_d_n = 1'b1; state_n = S_ADDR_HI; end
            CMD_GO:    begin start_n = 1'b1; state_n = S_RUN;     end
            default:   err_n = 1'b1;
          endcase
        end
        S_ADDR_HI: begin addr_n = {in_data, addr[7:0]};  state_n = S_ADDR_LO; end
        S_ADDR_LO: begin addr_n = {addr[15:8], in_data}; state_n = S_CNT_HI;  end
        S_CNT_HI:  begin cnt_n  = {in_data, cnt[7:0]};   state_n = S_CNT_LO;  end
        S_CNT_LO: begin
          cnt_n   = {cnt[15:8], in_data};
          state_n = (cnt_n == '0) ? FRAME_END : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (word_done_c) begin
            if (tgt_d) begin
              dcache_we_n = 1'b1;
              ddata_n     = word_c;
              daddr_n     = 32'(addr);
            end else begin
              icache_we_n = 1'b1;
              idata_n     = word_c;
              iaddr_n     = 32'(addr);
            end
            addr_n = addr + ADDR_W'(1);
            cnt_n  = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_n = FRAME_END;
          end
        end
`ifdef MIPS_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (in_data != csum) err_n = 1'b1;
          state_n = S_IDLE;
        end
`endif
        default: ;
      endcase
`ifdef MIPS_LOADER_CHECKSUM_EN
      // Running XOR covers everything between CMD and the check byte.
      if (state == S_IDLE)
        csum_n = '0;
      else if (state != S_CHECK && state != S_RUN)
        csum_n = csum ^ in_data;
`endif
    end
    in_ready_n = (state_n != S_RUN);
    busy_n     = !(state_n == S_IDLE || state_n == S_RUN);
  end

endmodule
